// File: rtl/regfile_wr_arbiter_if.sv
// Write-request and register-file write-port bundle shared by the two
// requesters and the arbiter.
interface regfile_wr_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
);
  localparam int NUM_BYTE = DATA_WIDTH / 8;

  logic                  req0_valid_i;
  logic                  req0_ready_o;
  logic [ADDR_WIDTH-1:0] req0_addr_i;
  logic [DATA_WIDTH-1:0] req0_data_i;
  logic [NUM_BYTE-1:0]   req0_be_i;

  logic                  req1_valid_i;
  logic                  req1_ready_o;
  logic [ADDR_WIDTH-1:0] req1_addr_i;
  logic [DATA_WIDTH-1:0] req1_data_i;
  logic [NUM_BYTE-1:0]   req1_be_i;

  logic                  rf_we_o;
  logic [ADDR_WIDTH-1:0] rf_waddr_o;
  logic [DATA_WIDTH-1:0] rf_wdata_o;
  logic [NUM_BYTE-1:0]   rf_wbe_o;
  logic                  merge_o;

  modport master (
    output req0_valid_i, req0_addr_i, req0_data_i, req0_be_i,
    output req1_valid_i, req1_addr_i, req1_data_i, req1_be_i,
    input  req0_ready_o, req1_ready_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o, rf_wbe_o, merge_o
  );

  modport slave (
    input  req0_valid_i, req0_addr_i, req0_data_i, req0_be_i,
    input  req1_valid_i, req1_addr_i, req1_data_i, req1_be_i,
    output req0_ready_o, req1_ready_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o, rf_wbe_o, merge_o
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Two-requester write arbiter for the register-file write port: fixed priority
// to requester 1, starvation escape for requester 0, same-address merging.
module regfile_wr_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_BYTE   = DATA_WIDTH / 8,
  parameter int MAX_WAIT   = 4
) (
  input logic             clk,
  input logic             rst,
  regfile_wr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    PRIO1 = 1'b0,
    PRIO0 = 1'b1
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  // Byte-wise combine: requester 1 wins overlapping bytes, unenabled bytes are 0.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] d0,
    input logic [NUM_BYTE-1:0]   be0,
    input logic [DATA_WIDTH-1:0] d1,
    input logic [NUM_BYTE-1:0]   be1
  );
    logic [DATA_WIDTH-1:0] res;
    res = '0;
    for (int i = 0; i < NUM_BYTE; i++) begin
      if (be1[i]) begin
        res[i*8 +: 8] = d1[i*8 +: 8];
      end else if (be0[i]) begin
        res[i*8 +: 8] = d0[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = 8'h00;
      end
    end
    return res;
  endfunction

  state_t                state_r;
  logic [7:0]            wait_cnt_r;
  logic                  rf_we_r;
  logic [ADDR_WIDTH-1:0] rf_waddr_r;
  logic [DATA_WIDTH-1:0] rf_wdata_r;
  logic [NUM_BYTE-1:0]   rf_wbe_r;
  logic                  merge_r;

  logic                  ready0_s;
  logic                  ready1_s;
  logic                  grant0_s;
  logic                  grant1_s;
  logic                  denied0_s;
  logic                  merge_s;
  logic [NUM_BYTE-1:0]   eff_be0_s;
  logic [NUM_BYTE-1:0]   eff_be1_s;
  logic [NUM_BYTE-1:0]   wbe_s;
  logic                  we_s;
  logic [ADDR_WIDTH-1:0] waddr_s;
  logic [DATA_WIDTH-1:0] wdata_s;

  // Grant decision: merge on equal addresses, otherwise the priority holder wins.
  always_comb begin
    ready0_s = 1'b0;
    ready1_s = 1'b0;
    if (rst) begin
      ready0_s = 1'b0;
      ready1_s = 1'b0;
    end else if (bus.req0_valid_i && bus.req1_valid_i) begin
      if (bus.req0_addr_i == bus.req1_addr_i) begin
        ready0_s = 1'b1;
        ready1_s = 1'b1;
      end else begin
        ready0_s = (state_r == PRIO0);
        ready1_s = (state_r == PRIO1);
      end
    end else begin
      ready0_s = bus.req0_valid_i;
      ready1_s = bus.req1_valid_i;
    end
  end

  // Next write-port contents built from whichever requests are accepted.
  always_comb begin
    grant0_s  = bus.req0_valid_i & ready0_s;
    grant1_s  = bus.req1_valid_i & ready1_s;
    denied0_s = bus.req0_valid_i & ~ready0_s;
    merge_s   = grant0_s & grant1_s;
    eff_be0_s = grant0_s ? bus.req0_be_i : {NUM_BYTE{1'b0}};
    eff_be1_s = grant1_s ? bus.req1_be_i : {NUM_BYTE{1'b0}};
    wbe_s     = eff_be0_s | eff_be1_s;
    we_s      = |wbe_s;
    waddr_s   = grant1_s ? bus.req1_addr_i : bus.req0_addr_i;
    wdata_s   = merge_bytes(bus.req0_data_i, eff_be0_s, bus.req1_data_i, eff_be1_s);
  end

  // Priority FSM, starvation counter and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= PRIO1;
      wait_cnt_r <= 8'd0;
      rf_we_r    <= 1'b0;
      rf_waddr_r <= '0;
      rf_wdata_r <= '0;
      rf_wbe_r   <= '0;
      merge_r    <= 1'b0;
    end else begin
      rf_we_r    <= we_s;
      rf_waddr_r <= waddr_s;
      rf_wdata_r <= wdata_s;
      rf_wbe_r   <= wbe_s;
      merge_r    <= merge_s & we_s;
      case (state_r)
        PRIO1: begin
          if (grant0_s) begin
            wait_cnt_r <= 8'd0;
          end else if (denied0_s) begin
            // Hand over priority on the edge where the count reaches MAX_WAIT.
            if (wait_cnt_r >= MAX_WAIT_C - 8'd1) begin
              wait_cnt_r <= MAX_WAIT_C;
              state_r    <= PRIO0;
            end else begin
              wait_cnt_r <= wait_cnt_r + 8'd1;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r;
          end
        end
        PRIO0: begin
          if (grant0_s) begin
            wait_cnt_r <= 8'd0;
            state_r    <= PRIO1;
          end else begin
            wait_cnt_r <= wait_cnt_r;
          end
        end
        default: begin
          state_r    <= PRIO1;
          wait_cnt_r <= 8'd0;
        end
      endcase
    end
  end

  assign bus.req0_ready_o = ready0_s;
  assign bus.req1_ready_o = ready1_s;
  assign bus.rf_we_o      = rf_we_r;
  assign bus.rf_waddr_o   = rf_waddr_r;
  assign bus.rf_wdata_o   = rf_wdata_r;
  assign bus.rf_wbe_o     = rf_wbe_r;
  assign bus.merge_o      = merge_r;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model and a reference memory.
module tb_regfile_wr_arbiter;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NB = 8;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_wr_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB), .MAX_WAIT(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: consecutive denials of requester 0, and the write expected next cycle.
  int          streak;
  logic        p_we, p_merge;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;
  logic [NB-1:0] p_be;
  logic [7:0]  model_mem [0:31][0:7];
  logic [7:0]  dut_mem   [0:31][0:7];

  logic        s_r0, s_r1, s_we, s_merge;
  logic [AW-1:0] s_waddr;
  logic [DW-1:0] s_wdata;
  logic [NB-1:0] s_wbe;
  int          run0, max_run0, merges;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic [NB-1:0] b0, input logic v1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1, input logic [NB-1:0] b1);
    bus.req0_valid_i = v0; bus.req0_addr_i = a0; bus.req0_data_i = d0; bus.req0_be_i = b0;
    bus.req1_valid_i = v1; bus.req1_addr_i = a1; bus.req1_data_i = d1; bus.req1_be_i = b1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  // One clock: check readies and write port at the negedge, then advance the model.
  task automatic cycle();
    logic m_r0, m_r1, acc0, acc1, e0, e1;
    @(negedge clk);
    if (bus.req0_valid_i && bus.req1_valid_i) begin
      if (bus.req0_addr_i == bus.req1_addr_i) begin
        m_r0 = 1'b1; m_r1 = 1'b1;
      end else begin
        m_r0 = (streak >= MW); m_r1 = !m_r0;
      end
    end else begin
      m_r0 = bus.req0_valid_i; m_r1 = bus.req1_valid_i;
    end
    s_r0 = bus.req0_ready_o; s_r1 = bus.req1_ready_o;
    s_we = bus.rf_we_o; s_waddr = bus.rf_waddr_o; s_wdata = bus.rf_wdata_o;
    s_wbe = bus.rf_wbe_o; s_merge = bus.merge_o;
    chk("ready0", s_r0, m_r0);
    chk("ready1", s_r1, m_r1);
    chk("rf_we", s_we, p_we);
    chk("merge", s_merge, p_merge);
    if (p_we) begin
      chk("rf_waddr", s_waddr, p_addr);
      chk("rf_wdata", s_wdata, p_data);
      chk("rf_wbe", s_wbe, p_be);
      for (int i = 0; i < NB; i++)
        if (p_be[i]) model_mem[p_addr][i] = p_data[i*8 +: 8];
    end
    if (s_we) begin
      for (int i = 0; i < NB; i++)
        if (s_wbe[i]) dut_mem[s_waddr][i] = s_wdata[i*8 +: 8];
    end
    if (s_merge) merges++;
    if (bus.req0_valid_i && !s_r0) run0++; else run0 = 0;
    if (run0 > max_run0) max_run0 = run0;
    acc0 = bus.req0_valid_i & m_r0;
    acc1 = bus.req1_valid_i & m_r1;
    for (int i = 0; i < NB; i++) begin
      e1 = acc1 & bus.req1_be_i[i];
      e0 = acc0 & bus.req0_be_i[i];
      p_be[i] = e1 | e0;
      p_data[i*8 +: 8] = e1 ? bus.req1_data_i[i*8 +: 8] : (e0 ? bus.req0_data_i[i*8 +: 8] : 8'h00);
    end
    p_we = |p_be;
    p_addr = acc1 ? bus.req1_addr_i : bus.req0_addr_i;
    p_merge = acc0 & acc1 & p_we;
    if (acc0) streak = 0; else if (bus.req0_valid_i) streak++;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    streak = 0; p_we = 1'b0; p_merge = 1'b0; p_addr = '0; p_data = '0; p_be = '0; run0 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 5'd1, 64'h1, 8'hFF, 1'b1, 5'd2, 64'h2, 8'hFF);
    @(negedge clk);
    chk("rst_ready0", bus.req0_ready_o, 1'b0);
    chk("rst_ready1", bus.req1_ready_o, 1'b0);
    chk("rst_we", bus.rf_we_o, 1'b0);
    chk("rst_fields", {bus.rf_waddr_o, bus.rf_wbe_o, bus.merge_o}, 64'h0);
    chk("rst_wdata", bus.rf_wdata_o, 64'h0);
    @(posedge clk);
    @(negedge clk);
    idle();
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  // Both requesters contend at different addresses for n cycles; req0 grant expected at grant_at.
  task automatic contend(input int n, input int grant_at, input string tag);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, 5'd1, 64'h0101010101010101, 8'hFF, 1'b1, 5'd2, 64'h0202020202020202, 8'hFF);
      cycle();
      chk(tag, s_r0, (k == grant_at) ? 1'b1 : 1'b0);
    end
    idle();
    cycle();
  endtask

  initial begin
    logic [DW-1:0] d0v, d1v;
    logic [AW-1:0] a0v, a1v;
    logic [NB-1:0] b0v, b1v;
    logic          v0v, v1v;
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < NB; b++) begin
        model_mem[a][b] = 8'h00; dut_mem[a][b] = 8'h00;
      end
    merges = 0; max_run0 = 0;
    model_clear();
    rst = 1'b1;
    idle();
    do_reset();

    // Single requester 1 write.
    drive(1'b0, '0, '0, '0, 1'b1, 5'd3, 64'h1122334455667788, 8'hFF);
    cycle();
    chk("t1_ready1", s_r1, 1'b1);
    idle();
    cycle();
    chk("t1_we", s_we, 1'b1);
    chk("t1_addr", s_waddr, 5'd3);
    chk("t1_data", s_wdata, 64'h1122334455667788);
    chk("t1_be", s_wbe, 8'hFF);
    chk("t1_merge", s_merge, 1'b0);
    cycle();
    chk("t1_we_after", s_we, 1'b0);

    // Starvation escape: four denials then req0 wins, then back to req1 priority.
    contend(6, 4, "t2_ready0");

    // Build up two denials, then a merge must clear the count.
    contend(2, -1, "t3_pre_ready0");
    drive(1'b1, 5'd7, {8{8'hAA}}, 8'h0F, 1'b1, 5'd7, {8{8'hBB}}, 8'h3C);
    cycle();
    chk("t3_ready0", s_r0, 1'b1);
    chk("t3_ready1", s_r1, 1'b1);
    idle();
    cycle();
    chk("t3_be", s_wbe, 8'h3F);
    chk("t3_data", s_wdata, 64'h0000BBBBBBBBAAAA);
    chk("t3_merge", s_merge, 1'b1);
    contend(5, 4, "t3_post_ready0");

    // Zero byte enables: accepted but no write.
    drive(1'b1, 5'd9, 64'hDEAD, 8'h00, 1'b0, '0, '0, '0);
    cycle();
    chk("t4_ready0", s_r0, 1'b1);
    idle();
    cycle();
    chk("t4_we", s_we, 1'b0);

    // Asynchronous reset mid-flight with a partially built wait count.
    contend(3, -1, "t5_pre_ready0");
    drive(1'b0, '0, '0, '0, 1'b1, 5'd5, 64'hCAFE, 8'hFF);
    cycle();
    chk("t5_ready1", s_r1, 1'b1);
    #1;
    chk("t5_we_before", bus.rf_we_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_we_async", bus.rf_we_o, 1'b0);
    chk("t5_ready1_rst", bus.req1_ready_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    idle();
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    contend(5, 4, "t5_post_ready0");

    // Randomized traffic; a request that was not accepted holds its fields.
    v0v = 1'b0; v1v = 1'b0; a0v = '0; a1v = '0; d0v = '0; d1v = '0; b0v = '0; b1v = '0;
    s_r0 = 1'b0; s_r1 = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!(v0v && !s_r0)) begin
        v0v = ($urandom_range(3) != 0);
        a0v = 5'($urandom_range(3));
        d0v = {$urandom, $urandom};
        b0v = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
      end
      if (!(v1v && !s_r1)) begin
        v1v = ($urandom_range(3) != 0);
        a1v = 5'($urandom_range(3));
        d1v = {$urandom, $urandom};
        b1v = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
      end
      drive(v0v, a0v, d0v, b0v, v1v, a1v, d1v, b1v);
      cycle();
    end
    idle();
    cycle();
    cycle();

    for (int a = 0; a < 32; a++) begin
      logic [63:0] mw, dw;
      for (int b = 0; b < NB; b++) begin
        mw[b*8 +: 8] = model_mem[a][b];
        dw[b*8 +: 8] = dut_mem[a][b];
      end
      chk($sformatf("mem[%0d]", a), dw, mw);
    end
    chk("starvation_bound", (max_run0 <= MW + 1), 1'b1);
    chk("merges_seen", (merges > 0), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
